alu_core_pipe: RTL and testbench

ALU_CORE_PIPE -- requirements
Module: alu_core_pipe

---
 rtl/alu_core_pipe.sv | 159 +++++++++++++++
 tb/tb_alu_core_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_core_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, flags, CRC-3 tag and completion counter.
// Optional shifter (SLL/SRL on opcodes 110/111) is built only when ALU_CORE_PIPE_SHIFT_EN is defined.
module alu_core_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags,
    output logic [2:0]       out_crc,
    output logic             out_err,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } aluOp_e;

`ifdef ALU_CORE_PIPE_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    logic             s1Valid_q;
    logic [WIDTH-1:0] s1Res_q;
    logic [3:0]       s1Flags_q;
    logic             s1Err_q;

    logic             s2Valid_q;
    logic [WIDTH-1:0] s2Res_q;
    logic [3:0]       s2Flags_q;
    logic [2:0]       s2Crc_q;
    logic             s2Err_q;

    logic [CNT_W-1:0] doneCnt_q;
    logic [CNT_W-1:0] doneCnt_d;

    logic [WIDTH-1:0] s1Res_d;
    logic [3:0]       s1Flags_d;
    logic             s1Err_d;
    logic [2:0]       s2Crc_d;
    logic [WIDTH:0]   sumWide;
    logic             carry;
    logic             ovf;

    logic advance;
    logic accept;
    logic complete;

    // Serial CRC-3 (x^3+x+1), MSB first, zero init.
    function automatic logic [2:0] crc3(input logic [WIDTH+4:0] msg);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = WIDTH + 4; i >= 0; i--) begin
            fb = c[2] ^ msg[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    assign advance  = !s2Valid_q || out_ready;
    assign in_ready = advance || !s1Valid_q;
    assign accept   = in_valid && in_ready;
    assign complete = s2Valid_q && out_ready;

    always_comb begin
        s1Res_d = '0;
        sumWide = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        s1Err_d = 1'b0;
        case (in_op)
            OP_AND: s1Res_d = in_a & in_b;
            OP_OR:  s1Res_d = in_a | in_b;
            OP_ADD: begin
                sumWide = {1'b0, in_a} + {1'b0, in_b};
                s1Res_d = sumWide[WIDTH-1:0];
                carry   = sumWide[WIDTH];
                ovf     = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (s1Res_d[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the wide difference is the unsigned borrow.
                sumWide = {1'b0, in_a} - {1'b0, in_b};
                s1Res_d = sumWide[WIDTH-1:0];
                carry   = sumWide[WIDTH];
                ovf     = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (s1Res_d[WIDTH-1] != in_a[WIDTH-1]);
            end
`ifdef ALU_CORE_PIPE_SHIFT_EN
            OP_SLL: s1Res_d = in_a << in_b[SHW-1:0];
            OP_SRL: s1Res_d = in_a >> in_b[SHW-1:0];
`endif
            default: s1Err_d = 1'b1;
        endcase
        s1Flags_d = s1Err_d ? 4'b0000 : {carry, ovf, (s1Res_d == '0), s1Res_d[WIDTH-1]};
    end

    always_comb begin
        s2Crc_d   = s1Err_q ? 3'b000 : crc3({s1Res_q, 1'b0, s1Flags_q});
        doneCnt_d = doneCnt_q + CNT_W'(1);
    end

    // Data registers load only with real operations so idle outputs keep the last response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Res_q   <= '0;
            s1Flags_q <= 4'b0000;
            s1Err_q   <= 1'b0;
            s2Valid_q <= 1'b0;
            s2Res_q   <= '0;
            s2Flags_q <= 4'b0000;
            s2Crc_q   <= 3'b000;
            s2Err_q   <= 1'b0;
            doneCnt_q <= '0;
        end else begin
            if (in_ready) begin
                s1Valid_q <= accept;
                if (accept) begin
                    s1Res_q   <= s1Res_d;
                    s1Flags_q <= s1Flags_d;
                    s1Err_q   <= s1Err_d;
                end
            end
            if (advance) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Res_q   <= s1Res_q;
                    s2Flags_q <= s1Flags_q;
                    s2Crc_q   <= s2Crc_d;
                    s2Err_q   <= s1Err_q;
                end
            end
            if (complete) begin
                doneCnt_q <= doneCnt_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_res   = s2Res_q;
    assign out_flags = s2Flags_q;
    assign out_crc   = s2Crc_q;
    assign out_err   = s2Err_q;
    assign done_cnt  = doneCnt_q;

endmodule

// File: tb/tb_alu_core_pipe.sv
// Directed self-checking bench for alu_core_pipe (WIDTH=32, small counter to reach the wrap).
module tb_alu_core_pipe;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_res;
    logic [3:0]       out_flags;
    logic [2:0]       out_crc;
    logic             out_err;
    logic [CNT_W-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;
    int expDone  = 0;

    alu_core_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags), .out_crc(out_crc),
        .out_err(out_err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // CRC as polynomial remainder of msg*x^3 modulo 1011, by long division.
    function automatic logic [2:0] refCrc(input logic [31:0] r, input logic [3:0] f);
        logic [39:0] rem;
        rem = {r, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (rem[i]) rem[i -: 4] = rem[i -: 4] ^ 4'b1011;
        end
        return rem[2:0];
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [31:0] expRes,
                                 input logic [3:0] expFlags, input logic expErr);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
        checkOutput({tag, "_inrdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_res"}, out_res, expRes);
        checkOutput({tag, "_flags"}, out_flags, expFlags);
        checkOutput({tag, "_err"}, out_err, expErr);
        checkOutput({tag, "_crc"}, out_crc, expErr ? 3'b000 : refCrc(expRes, expFlags));
        @(negedge clk);
        expDone = (expDone + 1) % (1 << CNT_W);
        checkOutput({tag, "_done"}, done_cnt, expDone);
        checkOutput({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_res", out_res, 0);
        checkOutput("rst_flags", out_flags, 0);
        checkOutput("rst_crc", out_crc, 0);
        checkOutput("rst_err", out_err, 0);
        checkOutput("rst_done", done_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_inrdy", in_ready, 1);

        applyStimulus("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'h0000_0000, 4'b1010, 1'b0);
        applyStimulus("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 32'h8000_0000, 4'b0101, 1'b0);
        applyStimulus("sub_borrow", 32'h0000_0005, 32'h0000_0007, 3'b101, 32'hFFFF_FFFE, 4'b1001, 1'b0);
        applyStimulus("sub_sovf", 32'h8000_0000, 32'h0000_0001, 3'b101, 32'h7FFF_FFFF, 4'b0100, 1'b0);
        applyStimulus("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 4'b0001, 1'b0);
        applyStimulus("or", 32'h0000_1200, 32'h0000_0034, 3'b001, 32'h0000_1234, 4'b0000, 1'b0);
        applyStimulus("bad011", 32'h1234_5678, 32'h1234_5678, 3'b011, 32'h0, 4'b0000, 1'b1);
        applyStimulus("bad010", 32'hDEAD_BEEF, 32'h0000_0001, 3'b010, 32'h0, 4'b0000, 1'b1);
`ifdef ALU_CORE_PIPE_SHIFT_EN
        applyStimulus("sll", 32'h0000_0001, 32'h0000_001F, 3'b110, 32'h8000_0000, 4'b0001, 1'b0);
        applyStimulus("srl", 32'h8000_0000, 32'h0000_003F, 3'b111, 32'h0000_0001, 4'b0000, 1'b0);
`else
        applyStimulus("sll", 32'h0000_0001, 32'h0000_001F, 3'b110, 32'h0, 4'b0000, 1'b1);
        applyStimulus("srl", 32'h8000_0000, 32'h0000_003F, 3'b111, 32'h0, 4'b0000, 1'b1);
`endif

        // Backpressure: three back-to-back requests while the sink stalls for four edges.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expDone = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00; in_op = 3'b000;
        @(negedge clk);
        checkOutput("bp_rdy2", in_ready, 1);
        in_a = 32'h0; in_b = 32'h0; in_op = 3'b001;
        @(negedge clk);
        checkOutput("bp_rdy3", in_ready, 0);
        checkOutput("bp_v1", out_valid, 1);
        checkOutput("bp_r1", out_res, 32'hF000_F000);
        in_a = 32'h7; in_b = 32'h5; in_op = 3'b101;
        repeat (2) begin
            @(negedge clk);
            checkOutput("bp_hold_res", out_res, 32'hF000_F000);
            checkOutput("bp_hold_flags", out_flags, 4'b0001);
            checkOutput("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_r2", out_res, 32'h0);
        checkOutput("bp_f2", out_flags, 4'b0010);
        checkOutput("bp_v2", out_valid, 1);
        @(negedge clk);
        checkOutput("bp_r3", out_res, 32'h2);
        checkOutput("bp_f3", out_flags, 4'b0000);
        checkOutput("bp_v3", out_valid, 1);
        @(negedge clk);
        checkOutput("bp_empty", out_valid, 0);
        checkOutput("bp_done", done_cnt, 3);
        expDone = 3;

        // Reset with two operations in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 32'h1; in_b = 32'h1; in_op = 3'b100;
        repeat (2) @(negedge clk);
        checkOutput("rf_loaded", out_valid, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rf_async_valid", out_valid, 0);
        checkOutput("rf_async_done", done_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        expDone = 0;
        @(negedge clk);
        checkOutput("rf_inrdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rf_no_stale", out_valid, 0);
        end

        // Enough completions to wrap the 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            applyStimulus("wrap_add", 32'(i), 32'(i), 3'b100, 32'(2 * i),
                          (i == 0) ? 4'b0010 : 4'b0000, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
